line_mem_responder: RTL and testbench

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

---
 rtl/mem_msgs_pkg.sv | 31 +++
 rtl/line_mem_array.sv | 30 +++
 rtl/line_mem_responder.sv | 120 ++++++++++++
 tb/tb_line_mem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_msgs_pkg.sv
// rtl/mem_msgs_pkg.sv - shared 16-byte line memory request/response message types
package mem_msgs_pkg;

  typedef logic [2:0] mem_type_t;

  localparam mem_type_t MEM_TYPE_READ  = 3'd0;
  localparam mem_type_t MEM_TYPE_WRITE = 3'd1;
  localparam mem_type_t MEM_TYPE_INIT  = 3'd2;

  localparam logic [1:0] MEM_TEST_OK      = 2'b00;
  localparam logic [1:0] MEM_TEST_ILLEGAL = 2'b11;

  localparam int MEM_LINE_BYTES = 16;

  typedef struct packed {
    mem_type_t    msg_type;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    mem_type_t    msg_type;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

// File: rtl/line_mem_array.sv
// rtl/line_mem_array.sv - line storage with per-byte write enable and an asynchronous read port
module line_mem_array #(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic               clk,
  input  logic               write_en,
  input  logic [IDX_W-1:0]   write_index,
  input  logic [15:0]        byte_en,
  input  logic [127:0]       write_data,
  input  logic [IDX_W-1:0]   read_index,
  output logic [127:0]       read_data
);

  // Contents are deliberately not reset; they are undefined until written.
  logic [127:0] lines [NUM_LINES];

  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int b = 0; b < 16; b++) begin
        if (byte_en[b]) begin
          lines[write_index][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

  assign read_data = lines[read_index];

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - single-outstanding memory-side responder for 16-byte line requests
module line_mem_responder
  import mem_msgs_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int LATENCY   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreq_val,
  output logic          memreq_rdy,
  input  mem_req_16B_t  memreq_msg,
  output logic          memresp_val,
  input  logic          memresp_rdy,
  output mem_resp_16B_t memresp_msg
);

  localparam int IDX_W = $clog2(NUM_LINES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state, state_next;
  logic [3:0]    count, count_next;
  mem_resp_16B_t resp_q, resp_next;

  logic [IDX_W-1:0] line_index;
  logic [127:0]     line_data;
  logic             accept;
  logic             is_store;
  logic             is_legal;
  logic [4:0]       lane_count;
  logic [31:0]      lane_mask;
  logic [15:0]      byte_en;
  logic             unused_bits;

  assign line_index = memreq_msg.addr[4 +: IDX_W];
  assign accept     = (state == IDLE) && memreq_val;
  assign is_store   = (memreq_msg.msg_type == MEM_TYPE_WRITE) ||
                      (memreq_msg.msg_type == MEM_TYPE_INIT);
  assign is_legal   = (memreq_msg.msg_type <= MEM_TYPE_INIT);

  // len=0 means a full line; lanes shifted past byte 15 fall off the top of the mask.
  assign lane_count = (memreq_msg.len == 4'd0) ? 5'd16 : {1'b0, memreq_msg.len};
  assign lane_mask  = ((32'd1 << lane_count) - 32'd1) << memreq_msg.addr[3:0];
  assign byte_en    = lane_mask[15:0];

  assign unused_bits = ^{memreq_msg.addr[31:4+IDX_W], lane_mask[31:16]};

  line_mem_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk         (clk),
    .write_en    (accept && is_store),
    .write_index (line_index),
    .byte_en     (byte_en),
    .write_data  (memreq_msg.data),
    .read_index  (line_index),
    .read_data   (line_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      resp_q <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      resp_q <= resp_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    resp_next   = resp_q;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    case (state)
      IDLE: begin
        memreq_rdy = 1'b1;
        if (memreq_val) begin
          // Read data is captured now, so the response is frozen at acceptance.
          resp_next.msg_type = memreq_msg.msg_type;
          resp_next.opaque   = memreq_msg.opaque;
          resp_next.test     = is_legal ? MEM_TEST_OK : MEM_TEST_ILLEGAL;
          resp_next.len      = 4'd0;
          resp_next.data     = (memreq_msg.msg_type == MEM_TYPE_READ) ? line_data : '0;
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        memresp_val = 1'b1;
        if (memresp_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign memresp_msg = resp_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - self-checking bench for line_mem_responder
module tb_line_mem_responder;
  import mem_msgs_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int LINES = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_val = 1'b0;
  logic          resp_rdy = 1'b1;
  logic          sel = 1'b0;
  mem_req_16B_t  req_msg = '0;
  logic          rdy_a, val_a, rdy_b, val_b;
  mem_resp_16B_t msg_a, msg_b;
  logic          cur_rdy, cur_val;
  mem_resp_16B_t cur_msg;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mdl [LINES][16];

  always #5 clk = ~clk;

  assign cur_rdy = sel ? rdy_b : rdy_a;
  assign cur_val = sel ? val_b : val_a;
  assign cur_msg = sel ? msg_b : msg_a;

  line_mem_responder #(.NUM_LINES(LINES), .LATENCY(LAT_A)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (req_val & ~sel),
    .memreq_rdy  (rdy_a),
    .memreq_msg  (req_msg),
    .memresp_val (val_a),
    .memresp_rdy (resp_rdy),
    .memresp_msg (msg_a)
  );

  line_mem_responder #(.NUM_LINES(LINES), .LATENCY(LAT_B)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (req_val & sel),
    .memreq_rdy  (rdy_b),
    .memreq_msg  (req_msg),
    .memresp_val (val_b),
    .memresp_rdy (resp_rdy),
    .memresp_msg (msg_b)
  );

  typedef struct {
    mem_type_t    t;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
    logic [7:0]   op;
    logic [127:0] exp_data;
    logic [1:0]   exp_test;
  } vec_t;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic mem_req_16B_t mk_req(input mem_type_t t, input logic [31:0] a,
                                          input logic [3:0] l, input logic [127:0] d,
                                          input logic [7:0] op);
    mem_req_16B_t r;
    r.msg_type = t;
    r.opaque   = op;
    r.addr     = a;
    r.len      = l;
    r.data     = d;
    return r;
  endfunction

  function automatic void check_resp(input string tag, input mem_resp_16B_t r, input int lat,
                                     input mem_type_t t, input logic [7:0] op,
                                     input logic [127:0] d, input logic [1:0] test,
                                     input int elat);
    check({tag, "_type"}, r.msg_type, t);
    check({tag, "_opaque"}, r.opaque, op);
    check({tag, "_test"}, r.test, test);
    check({tag, "_len"}, r.len, 4'd0);
    check({tag, "_data"}, r.data, d);
    check({tag, "_latency"}, lat, elat);
  endfunction

  function automatic logic [127:0] mdl_line(input int idx);
    logic [127:0] r;
    for (int l = 0; l < 16; l++) r[8*l +: 8] = mdl[idx][l];
    return r;
  endfunction

  function automatic void mdl_store(input int idx, input int off, input int len, input logic [127:0] d);
    int n;
    n = (len == 0) ? 16 : len;
    for (int k = 0; k < n; k++) begin
      if (off + k < 16) mdl[idx][off + k] = d[8*(off + k) +: 8];
    end
  endfunction

  task automatic send(input mem_req_16B_t r, input logic rr);
    int n;
    @(negedge clk);
    n = 0;
    while (!cur_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_rdy) check("req_rdy_timeout", cur_rdy, 1'b1);
    req_msg  = r;
    req_val  = 1'b1;
    resp_rdy = rr;
    @(posedge clk);
    #1 req_val = 1'b0;
  endtask

  task automatic wait_val(output bit seen, output int lat, output mem_resp_16B_t m);
    seen = 1'b0;
    lat  = -1;
    m    = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cur_val) begin
        seen = 1'b1;
        lat  = i;
        m    = cur_msg;
        break;
      end
    end
    if (!seen) check("resp_timeout", seen, 1'b1);
  endtask

  task automatic txn(input mem_req_16B_t r, input int stall, output mem_resp_16B_t m, output int lat);
    bit seen;
    send(r, stall == 0);
    wait_val(seen, lat, m);
    if (seen && stall > 0) begin
      repeat (stall) @(negedge clk);
      check("stall_hold", {cur_val, cur_rdy, cur_msg}, {1'b1, 1'b0, m});
      resp_rdy = 1'b1;
    end
  endtask

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_0F1E2D3C_4B5A6978_87960123;
  localparam logic [127:0] D3 = 128'hCAFEF00D_13579BDF_2468ACE0_FEEDFACE;

  vec_t          vt[12];
  mem_resp_16B_t m, m0;
  int            lat;
  bit            seen;
  int            spurious;

  initial begin
    vt[0]  = '{MEM_TYPE_WRITE, 32'h0000_0040, 4'd0, D1, 8'h05, 128'h0, 2'b00};
    vt[1]  = '{MEM_TYPE_READ,  32'h0000_0040, 4'd0, 128'h0, 8'h06, D1, 2'b00};
    vt[2]  = '{MEM_TYPE_INIT,  32'h0000_0080, 4'd0, 128'h0, 8'h07, 128'h0, 2'b00};
    vt[3]  = '{MEM_TYPE_WRITE, 32'h0000_0084, 4'd4,
               {64'hFFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF, 32'h12345678}, 8'h08, 128'h0, 2'b00};
    vt[4]  = '{MEM_TYPE_READ,  32'h0000_0080, 4'd0, 128'h0, 8'h09,
               {64'h0, 32'hDEADBEEF, 32'h0}, 2'b00};
    vt[5]  = '{MEM_TYPE_WRITE, 32'h0000_0010, 4'd0, D2, 8'h0A, 128'h0, 2'b00};
    vt[6]  = '{MEM_TYPE_READ,  32'h0000_0410, 4'd0, 128'h0, 8'h0B, D2, 2'b00};
    vt[7]  = '{MEM_TYPE_WRITE, 32'h0000_008C, 4'd8, {16{8'hAA}}, 8'h0C, 128'h0, 2'b00};
    vt[8]  = '{MEM_TYPE_READ,  32'h0000_0080, 4'd0, 128'h0, 8'h0D,
               {32'hAAAAAAAA, 32'h0, 32'hDEADBEEF, 32'h0}, 2'b00};
    vt[9]  = '{MEM_TYPE_READ,  32'hFFFF_FC4F, 4'd3, 128'h0, 8'h0E, D1, 2'b00};
    vt[10] = '{3'd6,           32'h0000_0040, 4'd0, {128{1'b1}}, 8'h0F, 128'h0, 2'b11};
    vt[11] = '{MEM_TYPE_READ,  32'h0000_0040, 4'd0, 128'h0, 8'h10, D1, 2'b00};

    repeat (2) @(negedge clk);
    check("reset_val_a", val_a, 1'b0);
    check("reset_msg_a", msg_a, '0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_rdy_a", rdy_a, 1'b1);
    check("post_reset_val_b", val_b, 1'b0);
    check("post_reset_rdy_b", rdy_b, 1'b1);

    for (int i = 0; i < 12; i++) begin
      txn(mk_req(vt[i].t, vt[i].addr, vt[i].len, vt[i].data, vt[i].op), 0, m, lat);
      check_resp($sformatf("vec%0d", i), m, lat, vt[i].t, vt[i].op, vt[i].exp_data,
                 vt[i].exp_test, LAT_A + 1);
    end

    send(mk_req(MEM_TYPE_READ, 32'h40, 4'd0, 128'h0, 8'h20), 1'b0);
    wait_val(seen, lat, m0);
    check("bp_data", m0.data, D1);
    check("bp_latency", lat, LAT_A + 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {cur_val, cur_rdy, cur_msg}, {1'b1, 1'b0, m0});
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_release", {cur_val, cur_rdy}, 2'b01);

    send(mk_req(MEM_TYPE_WRITE, 32'h100, 4'd0, D3, 8'h30), 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("rst_wait_outputs", {val_a, rdy_a, msg_a}, {1'b0, 1'b1, 145'h0});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    spurious = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (val_a) spurious++;
    end
    check("rst_wait_no_resp", spurious, 0);
    txn(mk_req(MEM_TYPE_READ, 32'h100, 4'd0, 128'h0, 8'h31), 0, m, lat);
    check_resp("rst_wait_read", m, lat, MEM_TYPE_READ, 8'h31, D3, 2'b00, LAT_A + 1);

    send(mk_req(MEM_TYPE_READ, 32'h100, 4'd0, 128'h0, 8'h32), 1'b0);
    wait_val(seen, lat, m0);
    #2 reset = 1'b0;
    #1 check("rst_resp_outputs", {val_a, rdy_a, msg_a}, {1'b0, 1'b1, 145'h0});
    @(negedge clk);
    reset = 1'b1;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("rst_resp_after", {val_a, rdy_a}, 2'b01);

    sel = 1'b1;
    txn(mk_req(MEM_TYPE_INIT, 32'h40, 4'd0, D1, 8'h40), 0, m, lat);
    check_resp("b_init", m, lat, MEM_TYPE_INIT, 8'h40, 128'h0, 2'b00, LAT_B + 1);
    txn(mk_req(3'd5, 32'h40, 4'd0, {128{1'b1}}, 8'h41), 0, m, lat);
    check_resp("b_illegal", m, lat, 3'd5, 8'h41, 128'h0, 2'b11, LAT_B + 1);
    txn(mk_req(MEM_TYPE_READ, 32'h40, 4'd0, 128'h0, 8'h42), 2, m, lat);
    check_resp("b_read", m, lat, MEM_TYPE_READ, 8'h42, D1, 2'b00, LAT_B + 1);
    sel = 1'b0;

    for (int i = 0; i < LINES; i++) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      txn(mk_req(MEM_TYPE_INIT, 32'(i) << 4, 4'd0, d, 8'(i)), 0, m, lat);
      check_resp($sformatf("fill%0d", i), m, lat, MEM_TYPE_INIT, 8'(i), 128'h0, 2'b00, LAT_A + 1);
      mdl_store(i, 0, 0, d);
    end

    for (int i = 0; i < 150; i++) begin
      mem_type_t    t;
      logic [31:0]  a;
      logic [3:0]   l;
      logic [127:0] d, ed;
      logic [7:0]   op;
      int           r, idx, stall;
      r = $urandom_range(0, 9);
      if (r < 4)      t = MEM_TYPE_READ;
      else if (r < 7) t = MEM_TYPE_WRITE;
      else if (r < 8) t = MEM_TYPE_INIT;
      else            t = 3'($urandom_range(3, 7));
      a     = $urandom;
      l     = 4'($urandom_range(0, 15));
      d     = {$urandom, $urandom, $urandom, $urandom};
      op    = 8'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      idx   = (a / 16) % LINES;
      ed    = (t == MEM_TYPE_READ) ? mdl_line(idx) : 128'h0;
      txn(mk_req(t, a, l, d, op), stall, m, lat);
      check_resp($sformatf("rnd%0d", i), m, lat, t, op, ed,
                 (t > MEM_TYPE_INIT) ? 2'b11 : 2'b00, LAT_A + 1);
      if (t == MEM_TYPE_WRITE || t == MEM_TYPE_INIT) mdl_store(idx, a % 16, l, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
